cpu_attack_controller: RTL and testbench

Consumes the random (i, j) coordinate stream from the LFSR attack generator and turns it into one legal computer attack per turn on the player's 5×5 board. It rejects already-attacked cells by resampling, falls back to a deterministic scan after a bounded number of retries, and resolves hit or miss against the player ship map. It maintains the attacked/hit maps used by the VGA renderer and the game FSM, and signals when all player ship cells are sunk.

---
 rtl/battleship_pkg.sv | 33 +++
 rtl/cpu_attack_controller_if.sv | 35 +++
 rtl/cpu_attack_controller.sv | 154 +++++++++++++++
 tb/tb_cpu_attack_controller.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/battleship_pkg.sv
// Shared board geometry, FSM state type and cell-index helpers for the
// battleship CPU opponent.
package battleship_pkg;

  localparam int BOARD_N   = 5;
  localparam int CELLS     = BOARD_N * BOARD_N;
  localparam int MAX_RETRY = 8;

  typedef logic [CELLS-1:0] board_map_t;

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    CHECK,
    SCAN,
    APPLY,
    DONE
  } attack_state_t;

  function automatic logic [4:0] cell_index(input logic [2:0] i, input logic [2:0] j);
    return 5'(int'(i) * BOARD_N + int'(j));
  endfunction

  // Constant-N divide/mod, so these reduce to small lookup logic.
  function automatic logic [2:0] index_row(input logic [4:0] idx);
    return 3'(int'(idx) / BOARD_N);
  endfunction

  function automatic logic [2:0] index_col(input logic [4:0] idx);
    return 3'(int'(idx) % BOARD_N);
  endfunction

endpackage

// File: rtl/cpu_attack_controller_if.sv
// Request/result bundle between the game FSM (master) and the CPU attack
// controller (slave), including the board maps the renderer reads.
interface cpu_attack_controller_if;
  import battleship_pkg::*;

  logic       start;
  logic       new_game;
  logic [2:0] i_random;
  logic [2:0] j_random;
  board_map_t player_ships;
  logic [4:0] ship_cells_total;
  logic       busy;
  logic       done;
  logic [2:0] attack_i;
  logic [2:0] attack_j;
  logic       hit;
  logic       no_target;
  board_map_t attacked_map;
  board_map_t hit_map;
  logic [4:0] hits_count;
  logic       all_sunk;

  modport master (
    output start, new_game, i_random, j_random, player_ships, ship_cells_total,
    input  busy, done, attack_i, attack_j, hit, no_target,
           attacked_map, hit_map, hits_count, all_sunk
  );

  modport slave (
    input  start, new_game, i_random, j_random, player_ships, ship_cells_total,
    output busy, done, attack_i, attack_j, hit, no_target,
           attacked_map, hit_map, hits_count, all_sunk
  );

endinterface

// File: rtl/cpu_attack_controller.sv
// Picks one legal CPU attack per turn: random resampling with a bounded retry
// count, then a row-major scan fallback; resolves hit/miss and tracks the maps.
module cpu_attack_controller
  import battleship_pkg::*;
(
  input logic                    clk,
  input logic                    rst,
  cpu_attack_controller_if.slave bus
);

  attack_state_t state, next_state;

  logic [2:0] cand_i, cand_j;
  logic [2:0] retry;
  logic [4:0] scan_idx;
  logic       exhausted;
  logic       busy, finish;

  board_map_t attacked_map, hit_map;
  logic [4:0] hits_count;
  logic       all_sunk, hit, done, no_target;
  logic [2:0] attack_i, attack_j;

  logic [4:0] cand_idx;
  logic       cand_free, scan_done, scan_free, ship_here;
  logic [4:0] hits_after;

  // Out-of-range candidates are treated as occupied so they force a resample.
  assign cand_idx   = cell_index(cand_i, cand_j);
  assign cand_free  = (cand_i < 3'(BOARD_N)) && (cand_j < 3'(BOARD_N)) && !attacked_map[cand_idx];
  assign scan_done  = scan_idx >= 5'(CELLS);
  assign scan_free  = !scan_done && !attacked_map[scan_idx];
  assign ship_here  = bus.player_ships[cand_idx];
  assign hits_after = (ship_here && hits_count != 5'(CELLS)) ? hits_count + 5'd1 : hits_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (bus.new_game) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.start) next_state = SAMPLE;
        SAMPLE:  next_state = CHECK;
        CHECK: begin
          if (cand_free)                            next_state = APPLY;
          else if (retry == 3'(MAX_RETRY - 1))      next_state = SCAN;
          else                                      next_state = SAMPLE;
        end
        SCAN: begin
          if (scan_done)      next_state = DONE;
          else if (scan_free) next_state = APPLY;
        end
        APPLY:   next_state = DONE;
        DONE:    next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    busy   = (state != IDLE);
    finish = (state == DONE);
  end

  // done/no_target are registered off the DONE state, so the pulse lands one
  // edge after DONE is entered and new_game can still suppress it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cand_i       <= '0;
      cand_j       <= '0;
      retry        <= '0;
      scan_idx     <= '0;
      exhausted    <= 1'b0;
      attacked_map <= '0;
      hit_map      <= '0;
      hits_count   <= '0;
      all_sunk     <= 1'b0;
      hit          <= 1'b0;
      attack_i     <= '0;
      attack_j     <= '0;
      done         <= 1'b0;
      no_target    <= 1'b0;
    end else if (bus.new_game) begin
      exhausted    <= 1'b0;
      attacked_map <= '0;
      hit_map      <= '0;
      hits_count   <= '0;
      all_sunk     <= 1'b0;
      hit          <= 1'b0;
      attack_i     <= '0;
      attack_j     <= '0;
      done         <= 1'b0;
      no_target    <= 1'b0;
    end else begin
      done      <= finish;
      no_target <= finish && exhausted;
      case (state)
        IDLE: begin
          if (bus.start) begin
            retry     <= '0;
            exhausted <= 1'b0;
          end
        end
        SAMPLE: begin
          cand_i <= bus.i_random;
          cand_j <= bus.j_random;
        end
        CHECK: begin
          if (!cand_free) begin
            if (retry == 3'(MAX_RETRY - 1)) scan_idx <= '0;
            else                            retry    <= retry + 3'd1;
          end
        end
        SCAN: begin
          if (scan_done) begin
            exhausted <= 1'b1;
          end else if (scan_free) begin
            cand_i <= index_row(scan_idx);
            cand_j <= index_col(scan_idx);
          end else begin
            scan_idx <= scan_idx + 5'd1;
          end
        end
        APPLY: begin
          attacked_map[cand_idx] <= 1'b1;
          if (ship_here) hit_map[cand_idx] <= 1'b1;
          hit        <= ship_here;
          hits_count <= hits_after;
          all_sunk   <= hits_after >= bus.ship_cells_total;
          attack_i   <= cand_i;
          attack_j   <= cand_j;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy         = busy;
  assign bus.done         = done;
  assign bus.no_target    = no_target;
  assign bus.attack_i     = attack_i;
  assign bus.attack_j     = attack_j;
  assign bus.hit          = hit;
  assign bus.attacked_map = attacked_map;
  assign bus.hit_map      = hit_map;
  assign bus.hits_count   = hits_count;
  assign bus.all_sunk     = all_sunk;

endmodule

// File: tb/tb_cpu_attack_controller.sv
// Bench for cpu_attack_controller: directed vector table, abort sequences and
// a randomized run checked against a rules-level model of the attack choice.
module tb_cpu_attack_controller;
  import battleship_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;

  cpu_attack_controller_if bus ();

  cpu_attack_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  board_map_t exp_attacked, exp_hits_map, ships;
  int         exp_hits, total;
  logic       exp_all_sunk, exp_hit;
  logic [2:0] exp_ai, exp_aj;
  logic [2:0] gen_i [64];
  logic [2:0] gen_j [64];

  typedef struct {
    logic       fill_first;
    logic [2:0] gi;
    logic [2:0] gj;
    logic [2:0] ei;
    logic [2:0] ej;
    logic       ehit;
    logic       enot;
    int         lat;
    logic       hs;
  } vec_t;

  vec_t vecs [6];

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic reset_shadow();
    exp_attacked = '0;
    exp_hits_map = '0;
    exp_hits     = 0;
    exp_all_sunk = 1'b0;
    exp_hit      = 1'b0;
    exp_ai       = '0;
    exp_aj       = '0;
  endtask

  task automatic set_gen_const(input logic [2:0] i, input logic [2:0] j);
    for (int t = 0; t < 64; t++) begin
      gen_i[t] = i;
      gen_j[t] = j;
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check_output({tag, "_done"},      bus.done,         0);
    check_output({tag, "_busy"},      bus.busy,         0);
    check_output({tag, "_no_target"}, bus.no_target,    0);
    check_output({tag, "_attacked"},  bus.attacked_map, 0);
    check_output({tag, "_hit_map"},   bus.hit_map,      0);
    check_output({tag, "_hits"},      bus.hits_count,   0);
    check_output({tag, "_all_sunk"},  bus.all_sunk,     0);
    check_output({tag, "_hit"},       bus.hit,          0);
    check_output({tag, "_attack_i"},  bus.attack_i,     0);
    check_output({tag, "_attack_j"},  bus.attack_j,     0);
  endtask

  task automatic watch_quiet(input string name, input int cycles);
    int seen;
    seen = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done || bus.busy) seen++;
    end
    check_output(name, seen, 0);
  endtask

  // One full attack: start, then every cycle compare against the expected
  // before/after picture, the switch happening on the APPLY edge.
  task automatic apply_stimulus(input int lat, input logic [2:0] ei, input logic [2:0] ej,
                                input logic ehit, input logic enot, input logic hold_start);
    board_map_t new_map, new_hmap;
    int         new_hits, idx;
    logic       new_sunk, changed, applied;
    idx      = int'(ei) * BOARD_N + int'(ej);
    new_map  = exp_attacked;
    new_hmap = exp_hits_map;
    new_hits = exp_hits;
    if (!enot) begin
      new_map[idx] = 1'b1;
      if (ehit) begin
        new_hmap[idx] = 1'b1;
        if (new_hits < CELLS) new_hits++;
      end
    end
    new_sunk = enot ? exp_all_sunk : (new_hits >= total);

    @(negedge clk);
    bus.start    = 1'b1;
    bus.i_random = gen_i[0];
    bus.j_random = gen_j[0];
    for (int r = 0; r <= lat; r++) begin
      @(posedge clk);
      @(negedge clk);
      bus.start    = hold_start && (r < lat);
      bus.i_random = gen_i[r+1];
      bus.j_random = gen_j[r+1];
      changed = (r >= lat - 1);
      applied = changed && !enot;
      check_output("done",       bus.done,         r == lat);
      check_output("busy",       bus.busy,         r < lat);
      check_output("no_target",  bus.no_target,    (r == lat) && enot);
      check_output("attacked",   bus.attacked_map, changed ? new_map : exp_attacked);
      check_output("hit_map",    bus.hit_map,      changed ? new_hmap : exp_hits_map);
      check_output("hits_count", bus.hits_count,   changed ? new_hits : exp_hits);
      check_output("all_sunk",   bus.all_sunk,     changed ? new_sunk : exp_all_sunk);
      check_output("hit",        bus.hit,          applied ? ehit : exp_hit);
      check_output("attack_i",   bus.attack_i,     applied ? ei : exp_ai);
      check_output("attack_j",   bus.attack_j,     applied ? ej : exp_aj);
    end
    @(posedge clk);
    @(negedge clk);
    check_output("done_one_cycle", bus.done, 0);
    check_output("start_not_queued", bus.busy, 0);

    exp_attacked = new_map;
    exp_hits_map = new_hmap;
    exp_hits     = new_hits;
    exp_all_sunk = new_sunk;
    if (!enot) begin
      exp_ai  = ei;
      exp_aj  = ej;
      exp_hit = ehit;
    end
  endtask

  task automatic fill_board_except_last();
    for (int k = 0; k < CELLS - 1; k++) begin
      if (!exp_attacked[k]) begin
        set_gen_const(3'(k / BOARD_N), 3'(k % BOARD_N));
        apply_stimulus(4, 3'(k / BOARD_N), 3'(k % BOARD_N), ships[k], 1'b0, 1'b0);
      end
    end
  endtask

  // Rules model: sample n is the generator value just before edge 1+2n after
  // the start edge; 4 clocks for an accepted first sample, 2 more per retry,
  // otherwise the lowest free cell after MAX_RETRY failed samples.
  task automatic predict(output int lat, output logic [2:0] ei, output logic [2:0] ej,
                         output logic ehit, output logic enot);
    int f;
    lat  = -1;
    ei   = '0;
    ej   = '0;
    enot = 1'b0;
    for (int n = 0; n < MAX_RETRY; n++) begin
      if (lat < 0 && gen_i[1+2*n] < 3'(BOARD_N) && gen_j[1+2*n] < 3'(BOARD_N) &&
          !exp_attacked[int'(gen_i[1+2*n]) * BOARD_N + int'(gen_j[1+2*n])]) begin
        lat = 4 + 2 * n;
        ei  = gen_i[1+2*n];
        ej  = gen_j[1+2*n];
      end
    end
    if (lat < 0) begin
      f = -1;
      for (int k = 0; k < CELLS; k++)
        if (f < 0 && !exp_attacked[k]) f = k;
      if (f >= 0) begin
        lat = 2 * MAX_RETRY + 3 + f;
        ei  = 3'(f / BOARD_N);
        ej  = 3'(f % BOARD_N);
      end else begin
        lat  = 2 * MAX_RETRY + 3 + CELLS - 1;
        enot = 1'b1;
      end
    end
    ehit = !enot && ships[int'(ei) * BOARD_N + int'(ej)];
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         lat;
    logic [2:0] ei, ej;
    logic       ehit, enot;

    bus.start    = 1'b0;
    bus.new_game = 1'b0;
    bus.i_random = '0;
    bus.j_random = '0;
    ships        = 25'h1000001;
    total        = 2;
    bus.player_ships     = ships;
    bus.ship_cells_total = 5'(total);
    reset_shadow();

    repeat (3) @(negedge clk);
    check_idle_zero("in_reset");
    rst = 1'b1;
    @(negedge clk);
    check_idle_zero("after_reset");

    vecs[0] = '{1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 4,  1'b0};
    vecs[1] = '{1'b0, 3'd0, 3'd0, 3'd0, 3'd1, 1'b0, 1'b0, 20, 1'b0};
    vecs[2] = '{1'b0, 3'd7, 3'd2, 3'd0, 3'd2, 1'b0, 1'b0, 21, 1'b0};
    vecs[3] = '{1'b0, 3'd2, 3'd3, 3'd2, 3'd3, 1'b0, 1'b0, 4,  1'b1};
    vecs[4] = '{1'b1, 3'd0, 3'd0, 3'd4, 3'd4, 1'b1, 1'b0, 43, 1'b0};
    vecs[5] = '{1'b0, 3'd1, 3'd1, 3'd0, 3'd0, 1'b0, 1'b1, 43, 1'b0};

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].fill_first) fill_board_except_last();
      set_gen_const(vecs[v].gi, vecs[v].gj);
      apply_stimulus(vecs[v].lat, vecs[v].ei, vecs[v].ej, vecs[v].ehit, vecs[v].enot, vecs[v].hs);
    end
    check_output("table_all_sunk", bus.all_sunk, 1);
    check_output("table_hits", bus.hits_count, 2);

    // new_game while in CHECK on a full board: pending no_target done is dropped
    set_gen_const(3'd0, 3'd0);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_output("ng_busy_before", bus.busy, 1);
    bus.new_game = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.new_game = 1'b0;
    reset_shadow();
    check_idle_zero("ng_cleared");
    watch_quiet("ng_no_done", 50);
    apply_stimulus(4, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0);

    // async reset while scanning aborts with no done pulse
    set_gen_const(3'd0, 3'd0);
    @(negedge clk);
    bus.start = 1'b1;
    for (int r = 0; r <= 17; r++) begin
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
    end
    check_output("rst_busy_before", bus.busy, 1);
    rst = 1'b0;
    #1;
    reset_shadow();
    check_idle_zero("rst_async");
    @(negedge clk);
    rst = 1'b1;
    watch_quiet("rst_no_done", 50);
    check_idle_zero("rst_after");
    apply_stimulus(4, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0);

    // randomized games against the rules model
    for (int g = 0; g < 2; g++) begin
      @(negedge clk);
      bus.new_game = 1'b1;
      @(negedge clk);
      bus.new_game = 1'b0;
      reset_shadow();
      ships = 25'($urandom);
      total = $urandom_range(1, 25);
      bus.player_ships     = ships;
      bus.ship_cells_total = 5'(total);
      for (int a = 0; a < 28; a++) begin
        for (int t = 0; t < 64; t++) begin
          gen_i[t] = 3'($urandom_range(0, 5));
          gen_j[t] = 3'($urandom_range(0, 5));
        end
        predict(lat, ei, ej, ehit, enot);
        apply_stimulus(lat, ei, ej, ehit, enot, 1'($urandom_range(0, 1)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
